// File: rtl/booth_bcd_sequencer_if.sv
// Handshake and data bundle between the sequencer and its two engines:
// the Booth multiplier and the binary-to-BCD converter.
interface booth_bcd_sequencer_if #(
    parameter int OP_W   = 8,
    parameter int PROD_W = 16,
    parameter int MAG_W  = 15,
    parameter int BCD_W  = 20
);
    logic              mult_start;
    logic [OP_W-1:0]   mult_a;
    logic [OP_W-1:0]   mult_b;
    logic              mult_done;
    logic [PROD_W-1:0] mult_product;
    logic              bcd_start;
    logic [MAG_W-1:0]  bcd_bin;
    logic              bcd_done;
    logic [BCD_W-1:0]  bcd_code;

    // Sequencer side: issues start pulses and operands, receives results.
    modport master (
        output mult_start, mult_a, mult_b, bcd_start, bcd_bin,
        input  mult_done, mult_product, bcd_done, bcd_code
    );

    // Engine side: the multiplier and converter.
    modport slave (
        input  mult_start, mult_a, mult_b, bcd_start, bcd_bin,
        output mult_done, mult_product, bcd_done, bcd_code
    );
endinterface

// File: rtl/booth_bcd_sequencer.sv
// Controller for the signed multiply-and-display path: latches operands,
// runs the Booth multiplier, converts the product to sign + magnitude, runs
// the magnitude through the BCD converter and holds the digits and sign.
// Every output is a register; the combinational process computes the next
// value of every register so the outputs line up with the next state.
module booth_bcd_sequencer #(
    parameter int OP_W    = 8,
    parameter int PROD_W  = 16,
    parameter int MAG_W   = 15,
    parameter int BCD_W   = 20,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [OP_W-1:0]      op_a,
    input  logic [OP_W-1:0]      op_b,
    booth_bcd_sequencer_if.master eng,
    output logic                 busy,
    output logic                 result_valid,
    output logic [BCD_W-1:0]     result_bcd,
    output logic                 result_neg,
    output logic                 error
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, MULT_GO, MULT_WAIT, SIGN, BCD_GO, BCD_WAIT, ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [OP_W-1:0]   mult_a_reg, mult_a_next;
    logic [OP_W-1:0]   mult_b_reg, mult_b_next;
    logic              mult_start_reg, mult_start_next;
    logic [PROD_W-1:0] prod_reg, prod_next;
    logic              neg_reg, neg_next;
    logic [MAG_W-1:0]  bcd_bin_reg, bcd_bin_next;
    logic              bcd_start_reg, bcd_start_next;
    logic              busy_reg, busy_next;
    logic              result_valid_reg, result_valid_next;
    logic [BCD_W-1:0]  result_bcd_reg, result_bcd_next;
    logic              result_neg_reg, result_neg_next;
    logic              error_reg, error_next;

    // Truncated two's-complement negation: the low MAG_W bits of -product
    // equal the negation of the low MAG_W bits, and |product| fits MAG_W.
    logic [MAG_W-1:0]  mag;
    assign mag = prod_reg[PROD_W-1] ? (~prod_reg[MAG_W-1:0] + 1'b1)
                                    : prod_reg[MAG_W-1:0];

    // Register all state and outputs; reset clears everything to IDLE/zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            mult_a_reg       <= '0;
            mult_b_reg       <= '0;
            mult_start_reg   <= 1'b0;
            prod_reg         <= '0;
            neg_reg          <= 1'b0;
            bcd_bin_reg      <= '0;
            bcd_start_reg    <= 1'b0;
            busy_reg         <= 1'b0;
            result_valid_reg <= 1'b0;
            result_bcd_reg   <= '0;
            result_neg_reg   <= 1'b0;
            error_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            mult_a_reg       <= mult_a_next;
            mult_b_reg       <= mult_b_next;
            mult_start_reg   <= mult_start_next;
            prod_reg         <= prod_next;
            neg_reg          <= neg_next;
            bcd_bin_reg      <= bcd_bin_next;
            bcd_start_reg    <= bcd_start_next;
            busy_reg         <= busy_next;
            result_valid_reg <= result_valid_next;
            result_bcd_reg   <= result_bcd_next;
            result_neg_reg   <= result_neg_next;
            error_reg        <= error_next;
        end
    end

    // Next-state and next-output logic; start pulses are one cycle wide
    // because they default low and are only raised on entry to a GO state.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        mult_a_next       = mult_a_reg;
        mult_b_next       = mult_b_reg;
        mult_start_next   = 1'b0;
        prod_next         = prod_reg;
        neg_next          = neg_reg;
        bcd_bin_next      = bcd_bin_reg;
        bcd_start_next    = 1'b0;
        busy_next         = busy_reg;
        result_valid_next = result_valid_reg;
        result_bcd_next   = result_bcd_reg;
        result_neg_next   = result_neg_reg;
        error_next        = error_reg;

        case (state_reg)
            IDLE, ERR: begin
                if (start) begin
                    mult_a_next       = op_a;
                    mult_b_next       = op_b;
                    result_valid_next = 1'b0;
                    error_next        = 1'b0;
                    busy_next         = 1'b1;
                    mult_start_next   = 1'b1;
                    state_next        = MULT_GO;
                end
            end
            MULT_GO: begin
                cnt_next   = '0;
                state_next = MULT_WAIT;
            end
            MULT_WAIT: begin
                if (eng.mult_done) begin
                    prod_next  = eng.mult_product;
                    state_next = SIGN;
                end else begin
                    // The cycle the counter reaches TIMEOUT is the last one waited.
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_next == CNT_W'(TIMEOUT)) begin
                        error_next        = 1'b1;
                        busy_next         = 1'b0;
                        result_valid_next = 1'b0;
                        state_next        = ERR;
                    end
                end
            end
            SIGN: begin
                neg_next       = prod_reg[PROD_W-1];
                bcd_bin_next   = mag;
                bcd_start_next = 1'b1;
                state_next     = BCD_GO;
            end
            BCD_GO: begin
                cnt_next   = '0;
                state_next = BCD_WAIT;
            end
            BCD_WAIT: begin
                if (eng.bcd_done) begin
                    result_bcd_next   = eng.bcd_code;
                    result_neg_next   = neg_reg;
                    result_valid_next = 1'b1;
                    busy_next         = 1'b0;
                    state_next        = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                    if (cnt_next == CNT_W'(TIMEOUT)) begin
                        error_next        = 1'b1;
                        busy_next         = 1'b0;
                        result_valid_next = 1'b0;
                        state_next        = ERR;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign eng.mult_start = mult_start_reg;
    assign eng.mult_a     = mult_a_reg;
    assign eng.mult_b     = mult_b_reg;
    assign eng.bcd_start  = bcd_start_reg;
    assign eng.bcd_bin    = bcd_bin_reg;
    assign busy           = busy_reg;
    assign result_valid   = result_valid_reg;
    assign result_bcd     = result_bcd_reg;
    assign result_neg     = result_neg_reg;
    assign error          = error_reg;
endmodule

// File: tb/tb_booth_bcd_sequencer.sv
// Directed bench for booth_bcd_sequencer: the bench plays the multiplier and
// converter by hand, driving inputs and sampling outputs on the falling edge.
module tb_booth_bcd_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  op_a = '0;
    logic [7:0]  op_b = '0;
    logic        busy, result_valid, result_neg, error;
    logic [19:0] result_bcd;
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    booth_bcd_sequencer_if #(.OP_W(8), .PROD_W(16), .MAG_W(15), .BCD_W(20)) ifc ();

    booth_bcd_sequencer #(.OP_W(8), .PROD_W(16), .MAG_W(15), .BCD_W(20), .TIMEOUT(255)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .op_a         (op_a),
        .op_b         (op_b),
        .eng          (ifc),
        .busy         (busy),
        .result_valid (result_valid),
        .result_bcd   (result_bcd),
        .result_neg   (result_neg),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_mult_start"}, 32'(ifc.mult_start), 32'd0);
        check({tag, "_mult_a"}, 32'(ifc.mult_a), 32'd0);
        check({tag, "_mult_b"}, 32'(ifc.mult_b), 32'd0);
        check({tag, "_bcd_start"}, 32'(ifc.bcd_start), 32'd0);
        check({tag, "_bcd_bin"}, 32'(ifc.bcd_bin), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_bcd"}, 32'(result_bcd), 32'd0);
        check({tag, "_neg"}, 32'(result_neg), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
    endtask

    // One complete operation with the engines answering at the earliest point.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] prod, input logic [14:0] exp_bin,
                          input logic [19:0] code, input logic exp_neg);
        @(negedge clk); start = 1'b1; op_a = a; op_b = b;
        @(negedge clk); start = 1'b0; op_a = 8'h55; op_b = 8'hAA;
        check({tag, "_mult_start"}, 32'(ifc.mult_start), 32'd1);
        check({tag, "_mult_a"}, 32'(ifc.mult_a), 32'(a));
        check({tag, "_mult_b"}, 32'(ifc.mult_b), 32'(b));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_error_clr"}, 32'(error), 32'd0);
        @(negedge clk);
        check({tag, "_mult_start_pulse"}, 32'(ifc.mult_start), 32'd0);
        ifc.mult_done = 1'b1; ifc.mult_product = prod;
        @(negedge clk); ifc.mult_done = 1'b0; ifc.mult_product = 16'h0BAD;
        check({tag, "_bcd_start_early"}, 32'(ifc.bcd_start), 32'd0);
        @(negedge clk);
        check({tag, "_bcd_start"}, 32'(ifc.bcd_start), 32'd1);
        check({tag, "_bcd_bin"}, 32'(ifc.bcd_bin), 32'(exp_bin));
        @(negedge clk);
        check({tag, "_bcd_start_pulse"}, 32'(ifc.bcd_start), 32'd0);
        ifc.bcd_done = 1'b1; ifc.bcd_code = code;
        @(negedge clk); ifc.bcd_done = 1'b0; ifc.bcd_code = 20'hFFFFF;
        check({tag, "_valid"}, 32'(result_valid), 32'd1);
        check({tag, "_bcd"}, 32'(result_bcd), 32'(code));
        check({tag, "_neg"}, 32'(result_neg), 32'(exp_neg));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        check({tag, "_mult_a_hold"}, 32'(ifc.mult_a), 32'(a));
        $display("op %s a=%0d b=%0d bcd=%05h neg=%0d", tag, $signed(a), $signed(b), result_bcd, result_neg);
    endtask

    initial begin
        ifc.mult_done = 1'b0; ifc.mult_product = '0;
        ifc.bcd_done = 1'b0; ifc.bcd_code = '0;

        repeat (2) @(negedge clk);
        all_zero("reset");
        reset = 1'b0;

        // 12 * -5 = -60
        run_op("t1", 8'd12, 8'hFB, 16'hFFC4, 15'd60, 20'h00060, 1'b1);
        // Result holds while idle.
        repeat (3) @(negedge clk);
        check("t1_hold_bcd", 32'(result_bcd), 32'h00060);
        check("t1_hold_valid", 32'(result_valid), 32'd1);
        // -128 * -128 = 16384, largest magnitude
        run_op("t2", 8'h80, 8'h80, 16'h4000, 15'd16384, 20'h16384, 1'b0);
        // 0 * -7 = 0, no negative zero
        run_op("t3", 8'd0, 8'hF9, 16'h0000, 15'd0, 20'h00000, 1'b0);
        // -1 * 1 = -1
        run_op("t3b", 8'hFF, 8'd1, 16'hFFFF, 15'd1, 20'h00001, 1'b1);
        // 127 * -128 = -16256, most negative product
        run_op("t3c", 8'h7F, 8'h80, 16'hC080, 15'd16256, 20'h16256, 1'b1);

        // Test 4: start again during MULT_WAIT is ignored.
        @(negedge clk); start = 1'b1; op_a = 8'd3; op_b = 8'd4;
        @(negedge clk); start = 1'b0;
        check("t4_valid_clr", 32'(result_valid), 32'd0);
        check("t4_bcd_kept", 32'(result_bcd), 32'h16256);
        @(negedge clk); start = 1'b1; op_a = 8'd9; op_b = 8'd9;
        @(negedge clk); start = 1'b0;
        check("t4_no_restart", 32'(ifc.mult_start), 32'd0);
        check("t4_a_kept", 32'(ifc.mult_a), 32'd3);
        check("t4_b_kept", 32'(ifc.mult_b), 32'd4);
        check("t4_busy", 32'(busy), 32'd1);
        // done together with another start: done wins, start ignored
        ifc.mult_done = 1'b1; ifc.mult_product = 16'd12; start = 1'b1; op_a = 8'd1;
        @(negedge clk); ifc.mult_done = 1'b0; start = 1'b0;
        check("t4_a_kept2", 32'(ifc.mult_a), 32'd3);
        @(negedge clk);
        check("t4_bcd_start", 32'(ifc.bcd_start), 32'd1);
        check("t4_bcd_bin", 32'(ifc.bcd_bin), 32'd12);
        @(negedge clk); ifc.bcd_done = 1'b1; ifc.bcd_code = 20'h00012;
        @(negedge clk); ifc.bcd_done = 1'b0;
        check("t4_valid", 32'(result_valid), 32'd1);
        check("t4_bcd", 32'(result_bcd), 32'h00012);
        check("t4_neg", 32'(result_neg), 32'd0);
        $display("op t4 bcd=%05h neg=%0d", result_bcd, result_neg);

        // Test 5: multiplier never answers.
        @(negedge clk); start = 1'b1; op_a = 8'd2; op_b = 8'd2;
        @(negedge clk); start = 1'b0;
        check("t5_mult_start", 32'(ifc.mult_start), 32'd1);
        cyc = 0;
        while (error !== 1'b1 && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("t5_timeout_cycles", 32'(cyc), 32'd256);
        check("t5_error", 32'(error), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(result_valid), 32'd0);
        $display("op t5 timeout after %0d cycles error=%0d", cyc, error);
        repeat (2) @(negedge clk);
        check("t5_error_stays", 32'(error), 32'd1);
        // late done in ERR is ignored
        ifc.mult_done = 1'b1;
        @(negedge clk); ifc.mult_done = 1'b0;
        @(negedge clk);
        check("t5_late_done_err", 32'(error), 32'd1);
        check("t5_late_done_busy", 32'(busy), 32'd0);
        run_op("t5r", 8'hFA, 8'd7, 16'hFFD6, 15'd42, 20'h00042, 1'b1);

        // Test 6: reset in BCD_WAIT, converter completes afterwards.
        @(negedge clk); start = 1'b1; op_a = 8'd5; op_b = 8'd5;
        @(negedge clk); start = 1'b0;
        @(negedge clk); ifc.mult_done = 1'b1; ifc.mult_product = 16'd25;
        @(negedge clk); ifc.mult_done = 1'b0;
        @(negedge clk);
        check("t6_bcd_start", 32'(ifc.bcd_start), 32'd1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        all_zero("t6_after_reset");
        ifc.bcd_done = 1'b1; ifc.bcd_code = 20'h00025;
        @(negedge clk); ifc.bcd_done = 1'b0;
        all_zero("t6_late_done");
        $display("op t6 reset mid-op valid=%0d busy=%0d", result_valid, busy);
        // Sequencer is back in IDLE: a new operation runs normally.
        run_op("t6r", 8'd9, 8'd11, 16'd99, 15'd99, 20'h00099, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
